// File: rtl/fibonacci_checker_if.sv
// fibonacci_checker_if
//   Stream interface between a Fibonacci source and the checker.
//   Handshake: a beat transfers on a rising clock edge where vld && rdy.
//   vld, dbl, num and num2 must be held stable while vld=1 and rdy=0.
//   rdy may depend on checker state only, never on vld.
//   Signals:
//     vld   - beat valid (source -> checker)
//     dbl   - 1: beat carries num and num2; 0: num only
//     num   - first (or only) number of the beat
//     num2  - second number of the beat (used when dbl=1)
//     rdy   - checker accepts beats (checker -> source)
interface fibonacci_checker_if #(
    parameter int WIDTH = 16
);
    logic             vld;
    logic             dbl;
    logic [WIDTH-1:0] num;
    logic [WIDTH-1:0] num2;
    logic             rdy;

    modport master (output vld, output dbl, output num, output num2, input rdy);
    modport slave  (input vld, input dbl, input num, input num2, output rdy);
endinterface

// File: rtl/fibonacci_checker.sv
// fibonacci_checker
//   Consumes a Fibonacci stream (1, 1, 2, 3, 5, ... mod 2^WIDTH) at one or two
//   numbers per beat, counts matched numbers and latches the first mismatch.
//   Ports:
//     clk        - clock, rising edge
//     rst        - asynchronous active-low reset
//     clr        - synchronous restart, wins over a concurrent beat
//     s          - stream slave (vld, dbl, num, num2, rdy)
//     ok         - registered pulse: previous cycle's accepted beat fully matched
//     err        - sticky mismatch flag
//     err_index  - index of the first mismatching number
//     index      - count of numbers accepted and matched
//     state_dbg  - current FSM state (0 = RUN, 1 = ERROR)
module fibonacci_checker #(
    parameter int WIDTH = 16,
    parameter int IDX_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clr,
    fibonacci_checker_if.slave  s,
    output logic                ok,
    output logic                err,
    output logic [IDX_W-1:0]    err_index,
    output logic [IDX_W-1:0]    index,
    output logic                state_dbg
);
    typedef enum logic {RUN = 1'b0, ERROR = 1'b1} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] e0, e1, e0_nxt, e1_nxt;
    logic [IDX_W-1:0] index_nxt, err_index_nxt;
    logic             err_nxt, ok_nxt;
    logic             accept;

    // Next pair after consuming one or two values, truncated to WIDTH bits.
    logic [WIDTH-1:0] sum1, sum2;
    assign sum1 = e0 + e1;
    assign sum2 = e0 + (e1 << 1);

    assign s.rdy     = (state == RUN);
    assign accept    = s.vld && s.rdy;
    assign state_dbg = state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= RUN;
            e0        <= WIDTH'(1);
            e1        <= WIDTH'(1);
            index     <= '0;
            err       <= 1'b0;
            err_index <= '0;
            ok        <= 1'b0;
        end else begin
            state     <= state_nxt;
            e0        <= e0_nxt;
            e1        <= e1_nxt;
            index     <= index_nxt;
            err       <= err_nxt;
            err_index <= err_index_nxt;
            ok        <= ok_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        e0_nxt        = e0;
        e1_nxt        = e1;
        index_nxt     = index;
        err_nxt       = err;
        err_index_nxt = err_index;
        ok_nxt        = 1'b0;

        if (clr) begin
            state_nxt     = RUN;
            e0_nxt        = WIDTH'(1);
            e1_nxt        = WIDTH'(1);
            index_nxt     = '0;
            err_nxt       = 1'b0;
            err_index_nxt = '0;
        end else if (accept) begin
            if (s.num != e0) begin
                state_nxt     = ERROR;
                err_nxt       = 1'b1;
                err_index_nxt = index;
            end else if (!s.dbl) begin
                e0_nxt    = e1;
                e1_nxt    = sum1;
                index_nxt = index + IDX_W'(1);
                ok_nxt    = 1'b1;
            end else if (s.num2 != e1) begin
                // First half matched; index stays on the whole-beat boundary.
                state_nxt     = ERROR;
                err_nxt       = 1'b1;
                err_index_nxt = index + IDX_W'(1);
            end else begin
                e0_nxt    = sum1;
                e1_nxt    = sum2;
                index_nxt = index + IDX_W'(2);
                ok_nxt    = 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_fibonacci_checker.sv
// tb_fibonacci_checker
//   Directed bench for fibonacci_checker: single/double rate streams, wrap,
//   mismatches, clr priority and asynchronous reset.
module tb_fibonacci_checker;
    localparam int WIDTH = 16;
    localparam int IDX_W = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             clr = 1'b0;
    logic             ok, err, state_dbg;
    logic [IDX_W-1:0] err_index, index;

    int passed = 0;
    int total  = 0;

    // F(1)..F(26) mod 2^16, hand-computed.
    logic [WIDTH-1:0] fib [0:25] = '{
        16'd1, 16'd1, 16'd2, 16'd3, 16'd5, 16'd8, 16'd13, 16'd21, 16'd34,
        16'd55, 16'd89, 16'd144, 16'd233, 16'd377, 16'd610, 16'd987,
        16'd1597, 16'd2584, 16'd4181, 16'd6765, 16'd10946, 16'd17711,
        16'd28657, 16'd46368, 16'd9489, 16'd55857
    };

    fibonacci_checker_if #(.WIDTH(WIDTH)) bus ();

    fibonacci_checker #(.WIDTH(WIDTH), .IDX_W(IDX_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .s         (bus.slave),
        .ok        (ok),
        .err       (err),
        .err_index (err_index),
        .index     (index),
        .state_dbg (state_dbg)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic beat(input logic d, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        @(negedge clk);
        bus.vld = 1'b1; bus.dbl = d; bus.num = a; bus.num2 = b;
        @(posedge clk);
        #1;
        bus.vld = 1'b0;
    endtask

    task automatic do_clr();
        @(negedge clk);
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
    endtask

    initial begin
        bus.vld = 1'b0; bus.dbl = 1'b0; bus.num = '0; bus.num2 = '0;

        // Reset state
        #12;
        check("rst_index", index, 0);
        check("rst_err", err, 0);
        check("rst_err_index", err_index, 0);
        check("rst_ok", ok, 0);
        check("rst_rdy", bus.rdy, 1);
        @(negedge clk);
        rst = 1'b1;

        // Single rate 1,1,2,3,5,8
        for (int i = 0; i < 6; i++) begin
            beat(1'b0, fib[i], 16'd0);
            check("single_ok", ok, 1);
            check("single_index", index, i + 1);
            check("single_rdy", bus.rdy, 1);
        end
        check("single_err", err, 0);
        @(posedge clk); #1;
        check("idle_ok", ok, 0);

        // Double rate, then mixed single beat
        do_clr();
        check("clr_index", index, 0);
        beat(1'b1, 16'd1, 16'd1);
        check("dbl_ok1", ok, 1);
        check("dbl_index1", index, 2);
        beat(1'b1, 16'd2, 16'd3);
        check("dbl_ok2", ok, 1);
        check("dbl_index2", index, 4);
        beat(1'b1, 16'd5, 16'd8);
        check("dbl_ok3", ok, 1);
        check("dbl_index3", index, 6);
        beat(1'b0, 16'd13, 16'd0);
        check("mixed_ok", ok, 1);
        check("mixed_index", index, 7);

        // Wrap-around to index 25
        do_clr();
        for (int i = 0; i < 26; i++) begin
            beat(1'b0, fib[i], 16'd0);
            if (i >= 24) begin
                check("wrap_ok", ok, 1);
                check("wrap_err", err, 0);
            end
        end
        check("wrap_index", index, 26);

        // Single mismatch 1,1,2,4
        do_clr();
        beat(1'b0, 16'd1, 16'd0);
        beat(1'b0, 16'd1, 16'd0);
        beat(1'b0, 16'd2, 16'd0);
        beat(1'b0, 16'd4, 16'd0);
        check("mis_err", err, 1);
        check("mis_err_index", err_index, 3);
        check("mis_index", index, 3);
        check("mis_rdy", bus.rdy, 0);
        check("mis_ok", ok, 0);
        check("mis_state", state_dbg, 1);
        beat(1'b0, 16'd3, 16'd0);
        check("drop_index", index, 3);
        check("drop_err_index", err_index, 3);
        check("drop_ok", ok, 0);

        // clr with concurrent beat num=7 while in ERROR
        @(negedge clk);
        clr = 1'b1; bus.vld = 1'b1; bus.dbl = 1'b0; bus.num = 16'd7;
        @(posedge clk); #1;
        clr = 1'b0; bus.vld = 1'b0;
        check("clrbeat_err", err, 0);
        check("clrbeat_index", index, 0);
        check("clrbeat_rdy", bus.rdy, 1);
        check("clrbeat_ok", ok, 0);
        beat(1'b0, 16'd1, 16'd0);
        check("after_clr_ok", ok, 1);
        check("after_clr_index", index, 1);

        // Double mismatch on second half
        do_clr();
        beat(1'b1, 16'd1, 16'd1);
        beat(1'b1, 16'd2, 16'd4);
        check("dmis_err", err, 1);
        check("dmis_err_index", err_index, 3);
        check("dmis_index", index, 2);
        check("dmis_ok", ok, 0);

        // Double mismatch on first half
        do_clr();
        beat(1'b1, 16'd1, 16'd1);
        beat(1'b1, 16'd3, 16'd3);
        check("dmis0_err_index", err_index, 2);
        check("dmis0_index", index, 2);

        // Async reset mid-cycle during a double-rate stream at index 10
        do_clr();
        for (int i = 0; i < 10; i += 2) beat(1'b1, fib[i], fib[i+1]);
        check("pre_rst_index", index, 10);
        @(negedge clk);
        bus.vld = 1'b1; bus.dbl = 1'b1; bus.num = fib[10]; bus.num2 = fib[11];
        #2;
        rst = 1'b0;
        #1;
        check("arst_index", index, 0);
        check("arst_ok", ok, 0);
        check("arst_err", err, 0);
        bus.vld = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        beat(1'b1, 16'd1, 16'd1);
        check("post_rst_ok", ok, 1);
        check("post_rst_index", index, 2);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/fibonacci_checker.md
Name: fibonacci_checker

Overview:
- Stream consumer and checker for Fibonacci number sources, at single rate (one number per beat) or double rate (two numbers per beat).
- Tracks the expected sequence 1, 1, 2, 3, 5, … modulo 2^WIDTH and counts accepted numbers.
- On the first mismatch it latches an error, records the failing index and stops accepting input until cleared.
- Sits downstream of a Fibonacci generator in testbench and self-check paths.

Parameters:
- WIDTH, 16: data width of each number; all arithmetic is mod 2^WIDTH.
- IDX_W, 16: width of the index counter and of err_index.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-low (0 = reset).
- clr  input  1  synchronous restart to the initial state.
- vld  input  1  beat valid.
- dbl  input  1  1 = beat carries two numbers (num, num2); 0 = num only, num2 ignored.
- num  input  WIDTH  first (or only) number of the beat.
- num2  input  WIDTH  second number of the beat.
- rdy  output  1  checker accepts beats; combinational from state (1 in RUN, 0 in ERROR).
- ok  output  1  registered pulse: the previous cycle's accepted beat fully matched.
- err  output  1  sticky mismatch flag.
- err_index  output  IDX_W  index of the first mismatching number.
- index  output  IDX_W  count of numbers accepted and matched.

Behaviour:
- State and registers:
  - Two states, RUN and ERROR.
  - Internal expected pair (e0, e1) holds the next two sequence values.
  - A beat is accepted when vld && rdy. Beats with vld while rdy=0 are dropped with no effect.
- Reset (rst=0, async): state=RUN, (e0,e1)=(1,1), index=0, err=0, err_index=0, ok=0. Release is synchronous to clk through the usual flop behaviour.
- clr=1 at a clock edge: same values as reset. clr has priority over a concurrent vld beat, which is discarded.
- RUN, accepted single beat (dbl=0):
  - num==e0: (e0,e1) <= (e1, e0+e1); index <= index+1; ok <= 1.
  - num!=e0: state <= ERROR; err <= 1; err_index <= index; ok <= 0; expected values and index frozen.
- RUN, accepted double beat (dbl=1):
  - num==e0 and num2==e1: (e0,e1) <= (e0+e1, e0+2*e1); index <= index+2; ok <= 1.
  - num!=e0: error, err_index <= index.
  - num==e0, num2!=e1: error, err_index <= index+1. index still does not advance, so it counts only whole matched beats.
- ERROR: rdy=0; holds until clr or reset. err, err_index and index remain stable.
- Arithmetic: sums truncate to WIDTH bits (wrap, no saturation). e0+2*e1 is formed as e0+(e1<<1) truncated. index wraps mod 2^IDX_W.
- ok is 0 in every cycle not immediately following a fully matched accepted beat.
- Latency: ok, err and err_index update on the edge that accepts the beat, so they are visible the following cycle.
- Index convention: index k corresponds to Fibonacci F(k+1), i.e. index 0 → 1, index 1 → 1, index 2 → 2.
- Mixed dbl=0 and dbl=1 beats in one stream are legal. Expected values advance by the number of values consumed.

Test Plan:
- Single rate: reset, then vld beats num = 1,1,2,3,5,8 → ok high after each beat, index = 6, err = 0, rdy = 1 throughout.
- Double rate: beats (1,1),(2,3),(5,8) with dbl=1 → ok each beat, index = 6. Then a single beat num=13 → ok, index = 7.
- Wrap-around: feed the correct stream to index 25 → value at index 24 = 9489 (75025 mod 65536), at index 25 = 55857, both accepted with ok, err = 0.
- Mismatch:
  - Single: 1,1,2,4 → err = 1, err_index = 3, index = 3, rdy = 0. A following beat of 3 is ignored.
  - Double: (1,1),(2,4) → err_index = 3, index = 2.
- clr with a concurrent vld beat of num=7 while in ERROR → state RUN, err = 0, index = 0, beat discarded. Next beat num=1 → ok, index = 1.
- Async reset asserted mid-cycle during a double-rate stream at index 10 → outputs clear immediately without a clock edge. After release, a beat of 1,1 → index = 2.
